// File: rtl/ooo_completion_buffer_if.sv
// Decode, execute-unit and commit-side signals of the completion buffer.
// master drives allocation and completions; slave is the buffer itself.
interface ooo_completion_buffer_if #(
  parameter int IDX_W = 4
);
  logic             alloc_req;
  logic [4:0]       alloc_rd;
  logic [31:0]      alloc_pc;
  logic             alloc_halt;
  logic [IDX_W-1:0] alloc_index;
  logic             full;

  logic             done_a;
  logic             done_mu;
  logic             done_du;
  logic             done_ls;
  logic [IDX_W-1:0] index_a;
  logic [IDX_W-1:0] index_mu;
  logic [IDX_W-1:0] index_du;
  logic [IDX_W-1:0] index_ls;
  logic [31:0]      wdata_a;
  logic [31:0]      wdata_mu;
  logic [31:0]      wdata_du;
  logic [31:0]      wdata_ls;
  logic             exception_a;
  logic             exception_mu;
  logic             exception_du;
  logic             exception_ls;

  logic             mispredict;

  logic             rf_wen;
  logic [4:0]       rf_rd;
  logic [31:0]      rf_wdata;
  logic             retire;
  logic [31:0]      retire_pc;
  logic             exception_out;
  logic [31:0]      exception_pc;
  logic             halt_out;

  modport master (
    output alloc_req, alloc_rd, alloc_pc, alloc_halt,
    output done_a, done_mu, done_du, done_ls,
    output index_a, index_mu, index_du, index_ls,
    output wdata_a, wdata_mu, wdata_du, wdata_ls,
    output exception_a, exception_mu, exception_du, exception_ls,
    output mispredict,
    input  alloc_index, full,
    input  rf_wen, rf_rd, rf_wdata, retire, retire_pc,
    input  exception_out, exception_pc, halt_out
  );

  modport slave (
    input  alloc_req, alloc_rd, alloc_pc, alloc_halt,
    input  done_a, done_mu, done_du, done_ls,
    input  index_a, index_mu, index_du, index_ls,
    input  wdata_a, wdata_mu, wdata_du, wdata_ls,
    input  exception_a, exception_mu, exception_du, exception_ls,
    input  mispredict,
    output alloc_index, full,
    output rf_wen, rf_rd, rf_wdata, retire, retire_pc,
    output exception_out, exception_pc, halt_out
  );
endinterface

// File: rtl/ooo_completion_buffer.sv
// In-order retirement buffer: allocate in order, complete out of order,
// retire one completed head entry per cycle, flush on exception/mispredict.
module ooo_completion_buffer #(
  parameter int NUM_CB_ENTRY = 16,
  parameter int IDX_W = $clog2(NUM_CB_ENTRY)
) (
  input logic CLK,
  input logic RST,
  ooo_completion_buffer_if.slave cb
);
  localparam int N = NUM_CB_ENTRY;

  logic [N-1:0]     valid_q, valid_d;
  logic [N-1:0]     done_q, done_d;
  logic [N-1:0]     exc_q, exc_d;
  logic [N-1:0]     halt_q, halt_d;
  logic [4:0]       rd_q [N];
  logic [4:0]       rd_d [N];
  logic [31:0]      pc_q [N];
  logic [31:0]      pc_d [N];
  logic [31:0]      wdata_q [N];
  logic [31:0]      wdata_d [N];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             halt_out_q, halt_out_d;

  logic             full;
  logic             alloc_acc;
  logic             hv;
  logic             ret;
  logic             exc_out;
  logic             flush;

  logic [3:0]       dn;
  logic [3:0]       cex;
  logic [IDX_W-1:0] cidx [4];
  logic [31:0]      cwd [4];

  // Ascending unit order so that later (higher priority) units win.
  assign dn      = {cb.done_ls, cb.done_du, cb.done_mu, cb.done_a};
  assign cex     = {cb.exception_ls, cb.exception_du,
                    cb.exception_mu, cb.exception_a};
  assign cidx[0] = cb.index_a;
  assign cidx[1] = cb.index_mu;
  assign cidx[2] = cb.index_du;
  assign cidx[3] = cb.index_ls;
  assign cwd[0]  = cb.wdata_a;
  assign cwd[1]  = cb.wdata_mu;
  assign cwd[2]  = cb.wdata_du;
  assign cwd[3]  = cb.wdata_ls;

  assign full      = (count_q == (IDX_W+1)'(N));
  assign alloc_acc = cb.alloc_req && !full;
  assign hv        = valid_q[head_q] && done_q[head_q] && !halt_out_q;
  assign ret       = hv && !exc_q[head_q];
  assign exc_out   = hv && exc_q[head_q];
  assign flush     = exc_out || cb.mispredict;

  assign cb.alloc_index   = tail_q;
  assign cb.full          = full;
  assign cb.retire        = ret;
  assign cb.retire_pc     = ret ? pc_q[head_q] : '0;
  assign cb.rf_wen        = ret && (rd_q[head_q] != '0);
  assign cb.rf_rd         = ret ? rd_q[head_q] : '0;
  assign cb.rf_wdata      = ret ? wdata_q[head_q] : '0;
  assign cb.exception_out = exc_out;
  assign cb.exception_pc  = exc_out ? pc_q[head_q] : '0;
  assign cb.halt_out      = halt_out_q;

  always_comb begin
    valid_d    = valid_q;
    done_d     = done_q;
    exc_d      = exc_q;
    halt_d     = halt_q;
    rd_d       = rd_q;
    pc_d       = pc_q;
    wdata_d    = wdata_q;
    head_d     = head_q;
    tail_d     = tail_q;
    halt_out_d = halt_out_q;

    for (int u = 0; u < 4; u++) begin
      if (dn[u] && valid_q[cidx[u]]) begin
        done_d[cidx[u]]  = 1'b1;
        exc_d[cidx[u]]   = cex[u];
        wdata_d[cidx[u]] = cwd[u];
      end
    end

    if (alloc_acc) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      exc_d[tail_q]   = 1'b0;
      halt_d[tail_q]  = cb.alloc_halt;
      rd_d[tail_q]    = cb.alloc_rd;
      pc_d[tail_q]    = cb.alloc_pc;
      tail_d          = tail_q + 1'b1;
    end

    if (ret) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + 1'b1;
      if (halt_q[head_q]) halt_out_d = 1'b1;
    end

    count_d = count_q + (IDX_W+1)'(alloc_acc)
                      - (IDX_W+1)'(ret);

    // A committing head still commits; everything else is dropped.
    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      exc_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q    <= '0;
      done_q     <= '0;
      exc_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      halt_out_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      done_q     <= done_d;
      exc_q      <= exc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      halt_out_q <= halt_out_d;
    end
  end

  always_ff @(posedge CLK) begin
    halt_q  <= halt_d;
    rd_q    <= rd_d;
    pc_q    <= pc_d;
    wdata_q <= wdata_d;
  end
endmodule

// File: tb/tb_ooo_completion_buffer.sv
// Bench for ooo_completion_buffer: vector table, hand sequences and
// a retire-order scoreboard filled at allocation time.
module tb_ooo_completion_buffer;
  logic CLK = 1'b0;
  logic RST = 1'b1;

  ooo_completion_buffer_if #(.IDX_W(4)) cb ();

  ooo_completion_buffer #(.NUM_CB_ENTRY(16)) dut (
    .CLK(CLK),
    .RST(RST),
    .cb (cb.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [3:0]  idx;
  } sb_t;

  typedef struct {
    logic        al;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [3:0]  dn;
    logic [3:0]  idx;
    logic [31:0] wd;
    logic        e_ret;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic [3:0]  e_ai;
  } vec_t;

  sb_t         sbq[$];
  logic [31:0] wd_m [16];
  logic [3:0]  tail_m;
  int          cnt_m;
  int          n_chk;
  int          n_fail;
  vec_t        vt [9];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    cb.alloc_req    = 0;
    cb.alloc_rd     = 0;
    cb.alloc_pc     = 0;
    cb.alloc_halt   = 0;
    cb.done_a       = 0;
    cb.done_mu      = 0;
    cb.done_du      = 0;
    cb.done_ls      = 0;
    cb.index_a      = 0;
    cb.index_mu     = 0;
    cb.index_du     = 0;
    cb.index_ls     = 0;
    cb.wdata_a      = 0;
    cb.wdata_mu     = 0;
    cb.wdata_du     = 0;
    cb.wdata_ls     = 0;
    cb.exception_a  = 0;
    cb.exception_mu = 0;
    cb.exception_du = 0;
    cb.exception_ls = 0;
    cb.mispredict   = 0;
  endtask

  task automatic alloc(logic [4:0] rd, logic [31:0] pc,
                       logic h);
    cb.alloc_req  = 1;
    cb.alloc_rd   = rd;
    cb.alloc_pc   = pc;
    cb.alloc_halt = h;
  endtask

  // u: 0=a 1=mu 2=du 3=ls
  task automatic cmp(int u, logic [3:0] idx,
                     logic [31:0] wd, logic ex);
    case (u)
      0: begin
        cb.done_a = 1; cb.index_a = idx;
        cb.wdata_a = wd; cb.exception_a = ex;
      end
      1: begin
        cb.done_mu = 1; cb.index_mu = idx;
        cb.wdata_mu = wd; cb.exception_mu = ex;
      end
      2: begin
        cb.done_du = 1; cb.index_du = idx;
        cb.wdata_du = wd; cb.exception_du = ex;
      end
      default: begin
        cb.done_ls = 1; cb.index_ls = idx;
        cb.wdata_ls = wd; cb.exception_ls = ex;
      end
    endcase
  endtask

  task automatic model_clear();
    sbq.delete();
    tail_m = 0;
    cnt_m  = 0;
  endtask

  // Settle, score the cycle, then advance to just after the next edge.
  task automatic tick();
    sb_t e;
    logic full_m;
    #1;
    full_m = (cnt_m == 16);
    chk("full", 32'(cb.full), 32'(full_m));
    chk("alloc_index", 32'(cb.alloc_index), 32'(tail_m));
    if (cb.retire || cb.exception_out) begin
      if (sbq.size() == 0) begin
        chk("sb_empty", 32'(1), 32'(0));
      end else begin
        e = sbq[0];
        if (cb.exception_out) begin
          chk("exc_pc", cb.exception_pc, e.pc);
          chk("exc_wen", 32'(cb.rf_wen), 32'(0));
        end else begin
          void'(sbq.pop_front());
          cnt_m--;
          chk("sb_rd", 32'(cb.rf_rd), 32'(e.rd));
          chk("sb_pc", cb.retire_pc, e.pc);
          chk("sb_wd", cb.rf_wdata, wd_m[e.idx]);
          chk("sb_wen", 32'(cb.rf_wen), 32'(e.rd != 0));
        end
      end
    end
    if (cb.alloc_req && !full_m) begin
      sbq.push_back('{rd: cb.alloc_rd, pc: cb.alloc_pc,
                      idx: tail_m});
      tail_m++;
      cnt_m++;
    end
    if (cb.done_a)  wd_m[cb.index_a]  = cb.wdata_a;
    if (cb.done_mu) wd_m[cb.index_mu] = cb.wdata_mu;
    if (cb.done_du) wd_m[cb.index_du] = cb.wdata_du;
    if (cb.done_ls) wd_m[cb.index_ls] = cb.wdata_ls;
    if (cb.exception_out || cb.mispredict) model_clear();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_rst();
    clr();
    RST = 1;
    @(negedge CLK);
    RST = 0;
    model_clear();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 16; i++) wd_m[i] = 0;
    model_clear();
    clr();

    vt[0] = '{1, 5, 32'h200, 0, 0, 0, 0, 0, 0, 0};
    vt[1] = '{1, 6, 32'h204, 0, 0, 0, 0, 0, 0, 1};
    vt[2] = '{1, 7, 32'h208, 0, 0, 0, 0, 0, 0, 2};
    vt[3] = '{0, 0, 0, 4'b0010, 2, 32'h33, 0, 0, 0, 3};
    vt[4] = '{0, 0, 0, 4'b0001, 0, 32'h11, 0, 0, 0, 3};
    vt[5] = '{0, 0, 0, 4'b0100, 1, 32'h22, 1, 5, 32'h11, 3};
    vt[6] = '{0, 0, 0, 0, 0, 0, 1, 6, 32'h22, 3};
    vt[7] = '{0, 0, 0, 0, 0, 0, 1, 7, 32'h33, 3};
    vt[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 3};

    // Power-on reset state
    #2;
    chk("rst_full", 32'(cb.full), 0);
    chk("rst_retire", 32'(cb.retire), 0);
    chk("rst_halt", 32'(cb.halt_out), 0);
    chk("rst_exc", 32'(cb.exception_out), 0);
    chk("rst_ai", 32'(cb.alloc_index), 0);
    @(negedge CLK);
    RST = 0;
    @(posedge CLK);
    #1;

    // Reset mid-operation
    for (int i = 0; i < 3; i++) begin
      clr();
      alloc(5'(i + 1), 32'h50 + 32'(i * 4), 0);
      tick();
    end
    clr();
    RST = 1;
    #1;
    chk("mid_full", 32'(cb.full), 0);
    chk("mid_retire", 32'(cb.retire), 0);
    chk("mid_halt", 32'(cb.halt_out), 0);
    chk("mid_ai", 32'(cb.alloc_index), 0);
    @(negedge CLK);
    RST = 0;
    model_clear();
    @(posedge CLK);
    #1;
    chk("post_rst_ai", 32'(cb.alloc_index), 0);

    // In-order retirement from the vector table
    for (int v = 0; v < 9; v++) begin
      clr();
      if (vt[v].al) alloc(vt[v].rd, vt[v].pc, 0);
      for (int u = 0; u < 4; u++)
        if (vt[v].dn[u]) cmp(u, vt[v].idx, vt[v].wd, 0);
      #1;
      chk($sformatf("v%0d_ret", v), 32'(cb.retire),
          32'(vt[v].e_ret));
      chk($sformatf("v%0d_ai", v), 32'(cb.alloc_index),
          32'(vt[v].e_ai));
      if (vt[v].e_ret) begin
        chk($sformatf("v%0d_rd", v), 32'(cb.rf_rd),
            32'(vt[v].e_rd));
        chk($sformatf("v%0d_wd", v), cb.rf_wdata, vt[v].e_wd);
      end
      tick();
    end

    // Fill and wrap
    do_rst();
    for (int i = 0; i < 16; i++) begin
      clr();
      alloc(5'(i + 1), 32'h1000 + 32'(i * 4), 0);
      tick();
    end
    chk("fill_full", 32'(cb.full), 1);
    clr();
    alloc(5'd30, 32'h1fff0, 0);
    tick();
    clr();
    alloc(5'd30, 32'h1fff0, 0);
    cmp(0, 0, 32'ha0, 0);
    tick();
    clr();
    alloc(5'd30, 32'h1fff0, 0);
    #1;
    chk("wrap_ret", 32'(cb.retire), 1);
    chk("wrap_full", 32'(cb.full), 1);
    tick();
    clr();
    alloc(5'd20, 32'h2000, 0);
    #1;
    chk("wrap_free", 32'(cb.full), 0);
    chk("wrap_ai", 32'(cb.alloc_index), 0);
    tick();
    clr();
    #1;
    chk("wrap_refull", 32'(cb.full), 1);

    // Exception at head
    do_rst();
    clr(); alloc(5'd1, 32'h100, 0); tick();
    clr(); alloc(5'd2, 32'h104, 0); tick();
    clr();
    cmp(0, 1, 32'h44, 0);
    cmp(3, 0, 32'hdead, 1);
    tick();
    clr();
    #1;
    chk("exc_out", 32'(cb.exception_out), 1);
    chk("exc_pc0", cb.exception_pc, 32'h100);
    chk("exc_wen0", 32'(cb.rf_wen), 0);
    chk("exc_noret", 32'(cb.retire), 0);
    tick();
    clr();
    #1;
    chk("exc_ai", 32'(cb.alloc_index), 0);
    chk("exc_after", 32'(cb.retire), 0);
    chk("exc_after_x", 32'(cb.exception_out), 0);
    tick();

    // Mispredict with head retiring in the same cycle
    do_rst();
    for (int i = 0; i < 4; i++) begin
      clr();
      alloc(5'(10 + i), 32'h300 + 32'(i * 4), 0);
      tick();
    end
    clr();
    cmp(2, 0, 32'h55, 0);
    tick();
    clr();
    cb.mispredict = 1;
    #1;
    chk("mp_ret", 32'(cb.retire), 1);
    chk("mp_rd", 32'(cb.rf_rd), 10);
    chk("mp_wen", 32'(cb.rf_wen), 1);
    tick();
    clr();
    cmp(0, 1, 32'h66, 0);
    #1;
    chk("mp_flushed", 32'(cb.retire), 0);
    tick();
    clr();
    alloc(5'd9, 32'h380, 0);
    #1;
    chk("mp_late", 32'(cb.retire), 0);
    chk("mp_ai", 32'(cb.alloc_index), 0);
    tick();
    clr();
    #1;
    chk("mp_new_nd", 32'(cb.retire), 0);
    tick();

    // rd=0, completion priority, then halt
    do_rst();
    clr(); alloc(5'd0, 32'h400, 0); tick();
    clr(); alloc(5'd3, 32'h404, 0); tick();
    clr(); alloc(5'd4, 32'h408, 1); tick();
    clr(); alloc(5'd8, 32'h40c, 0); tick();
    clr();
    cmp(1, 0, 32'h77, 0);
    tick();
    clr();
    cmp(0, 1, 32'h1, 0);
    cmp(3, 1, 32'h99, 0);
    #1;
    chk("rd0_ret", 32'(cb.retire), 1);
    chk("rd0_wen", 32'(cb.rf_wen), 0);
    tick();
    clr();
    cmp(0, 2, 32'h0, 0);
    cmp(2, 3, 32'h88, 0);
    #1;
    chk("prio_rd", 32'(cb.rf_rd), 3);
    chk("prio_wd", cb.rf_wdata, 32'h99);
    tick();
    clr();
    #1;
    chk("halt_ret", 32'(cb.retire), 1);
    chk("halt_pre", 32'(cb.halt_out), 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      clr();
      #1;
      chk("halt_set", 32'(cb.halt_out), 1);
      chk("halt_stop", 32'(cb.retire), 0);
      tick();
    end
    clr();
    alloc(5'd11, 32'h500, 0);
    #1;
    chk("halt_ai", 32'(cb.alloc_index), 4);
    tick();
    clr();
    #1;
    chk("halt_ai2", 32'(cb.alloc_index), 5);
    chk("halt_keep", 32'(cb.halt_out), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
